// File: rtl/axi4_write_master_if.sv
// Command, write-data and AXI4 write-channel bundle for axi4_write_master.
// master: the burst engine side; slave: the command source / AXI slave side.
interface axi4_write_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [ADDR_WIDTH-1:0]   cmd_addr;
   logic [7:0]              cmd_len;
   logic                    wr_valid;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic                    wr_ready;
   logic                    done;
   logic [1:0]              resp;
   logic                    busy;
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic [7:0]              AWLEN;
   logic [2:0]              AWSIZE;
   logic [1:0]              AWBURST;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WLAST;
   logic                    WVALID;
   logic                    WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len,
      output cmd_ready,
      input  wr_valid, wr_data,
      output wr_ready,
      output done, resp, busy,
      output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BRESP, BVALID,
      output BREADY
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len,
      input  cmd_ready,
      output wr_valid, wr_data,
      input  wr_ready,
      input  done, resp, busy,
      input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BRESP, BVALID,
      input  BREADY
   );
endinterface

// File: rtl/axi4_write_master.sv
// Single-burst AXI4 write master: takes one command, issues AW, streams
// wr_* beats onto W, waits for B, then pulses done with the response.
// Ports: ACLK, ARESETn (async, active low), bus (axi4_write_master_if.master).
module axi4_write_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input logic                 ACLK,
   input logic                 ARESETn,
   axi4_write_master_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      RESP,
      DONE
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            cnt_q;
   logic [1:0]            resp_q;

   logic        accept;
   logic        illegal;
   logic        w_fire;
   logic        last_beat;
   logic [12:0] end_off;

   // Byte offset one past the burst within its 4 KB page; beyond 4096
   // means the burst would cross a page boundary.
   assign end_off = {1'b0, bus.cmd_addr[11:0]}
                  + {3'b000, bus.cmd_len, 2'b00}
                  + 13'd4;
   assign illegal = (bus.cmd_addr[1:0] != 2'b00)
                  || (end_off > 13'd4096);

   assign accept    = (state_q == IDLE) && bus.cmd_valid;
   assign last_beat = (cnt_q == len_q);
   assign w_fire    = (state_q == DATA)
                   && bus.wr_valid && bus.WREADY;

   assign bus.AWADDR  = addr_q;
   assign bus.AWLEN   = len_q;
   assign bus.AWSIZE  = 3'b010;
   assign bus.AWBURST = 2'b01;
   assign bus.WDATA   = bus.wr_data;
   assign bus.WSTRB   = {(DATA_WIDTH/8){1'b1}};
   assign bus.busy    = (state_q != IDLE);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         resp_q <= '0;
      end else begin
         if (accept) begin
            addr_q <= bus.cmd_addr;
            len_q  <= bus.cmd_len;
            resp_q <= illegal ? 2'b10 : 2'b00;
         end
         // Counter restarts as the AW handshake moves us into DATA.
         if ((state_q == ADDR) && bus.AWREADY) begin
            cnt_q <= '0;
         end else if (w_fire) begin
            cnt_q <= cnt_q + 8'd1;
         end
         if ((state_q == RESP) && bus.BVALID) begin
            resp_q <= bus.BRESP;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      bus.cmd_ready = 1'b0;
      bus.AWVALID  = 1'b0;
      bus.WVALID   = 1'b0;
      bus.wr_ready = 1'b0;
      bus.WLAST    = 1'b0;
      bus.BREADY   = 1'b0;
      bus.done     = 1'b0;
      bus.resp     = 2'b00;
      unique case (state_q)
         IDLE: begin
            // Reset drives state to IDLE; keep cmd_ready low until release.
            bus.cmd_ready = ARESETn;
            if (bus.cmd_valid && ARESETn) begin
               state_d = illegal ? DONE : ADDR;
            end
         end
         ADDR: begin
            bus.AWVALID = 1'b1;
            if (bus.AWREADY) begin
               state_d = DATA;
            end
         end
         DATA: begin
            bus.WVALID   = bus.wr_valid;
            bus.wr_ready = bus.WREADY;
            bus.WLAST    = last_beat;
            if (w_fire && last_beat) begin
               state_d = RESP;
            end
         end
         RESP: begin
            bus.BREADY = 1'b1;
            if (bus.BVALID) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.done = 1'b1;
            bus.resp = resp_q;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi4_write_master.sv
// Directed bench for axi4_write_master: queue-based model of expected
// AW/W/done traffic plus literal checks on a few hand-computed results.
module tb_axi4_write_master;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   axi4_write_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

   axi4_write_master #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(16)
   ) dut (
      .ACLK(ACLK),
      .ARESETn(ARESETn),
      .bus(bus.master)
   );

   int checks = 0;
   int errors = 0;

   // expected traffic
   logic [23:0] exp_aw[$];
   logic [32:0] exp_w[$];
   logic [1:0]  exp_resp[$];
   logic [31:0] src_q[$];

   // stimulus knobs
   int       aw_delay = 0;
   bit       gaps = 0;
   bit       wtog = 0;
   bit       stray = 0;
   logic [1:0] bresp_cfg = 2'b00;

   // observation
   int  cyc = 0;
   bit  aw_fire, w_fire, w_last_fire, b_fire, aw_seen;
   int  aw_cycles = 0, w_count = 0, wlast_count = 0, done_count = 0;
   int  acc_cyc = 0, done_cyc = 0;
   logic [15:0] last_awaddr;
   logic [7:0]  last_awlen;
   logic [31:0] last_wdata_last;
   logic [1:0]  last_resp;
   logic [28:0] aw_prev;
   bit          aw_prev_valid = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // slave / data-source driver, updates just after each rising edge
   int  aw_wait = 0;
   bit  b_pending = 0;
   initial begin
      bus.AWREADY = 1'b1;
      bus.WREADY  = 1'b1;
      bus.BVALID  = 1'b0;
      bus.BRESP   = 2'b00;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      forever begin
         @(posedge ACLK);
         #1;
         cyc++;
         if (w_fire && src_q.size() > 0) void'(src_q.pop_front());
         if (!ARESETn) begin
            aw_wait = 0;
            b_pending = 0;
         end else begin
            if (aw_fire) aw_wait = 0;
            else if (aw_seen) aw_wait++;
            if (w_last_fire) b_pending = 1;
            if (b_fire) b_pending = 0;
         end
         bus.AWREADY  = (aw_wait >= aw_delay);
         bus.WREADY   = !wtog || cyc[0];
         bus.wr_valid = (src_q.size() > 0) && (!gaps || (cyc % 3 != 1));
         bus.wr_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
         bus.BVALID   = b_pending || stray;
         bus.BRESP    = bresp_cfg;
      end
   end

   // compare process, mid-cycle
   always @(negedge ACLK) begin
      logic [23:0] aw_e;
      logic [32:0] w_e;
      logic [1:0]  r_e;
      bit          in_data;
      aw_fire     = bus.AWVALID && bus.AWREADY;
      w_fire      = bus.WVALID && bus.WREADY;
      w_last_fire = w_fire && bus.WLAST;
      b_fire      = bus.BVALID && bus.BREADY;
      aw_seen     = bus.AWVALID;
      if (!ARESETn) begin
         aw_prev_valid = 0;
         chk("reset_outputs_zero",
             {bus.cmd_ready, bus.wr_ready, bus.done, bus.resp, bus.busy,
              bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY}, 0);
      end else begin
         if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
         if (bus.AWVALID) begin
            aw_cycles++;
            if (aw_prev_valid)
               chk("aw_payload_stable",
                   {bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST}, aw_prev);
            aw_prev = {bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST};
         end
         aw_prev_valid = bus.AWVALID && !bus.AWREADY;
         if (aw_fire) begin
            last_awaddr = bus.AWADDR;
            last_awlen  = bus.AWLEN;
            if (exp_aw.size() == 0) begin
               chk("aw_unexpected", 1, 0);
            end else begin
               aw_e = exp_aw.pop_front();
               chk("aw_addr_len", {bus.AWADDR, bus.AWLEN}, aw_e);
               chk("aw_size_burst", {bus.AWSIZE, bus.AWBURST}, 5'b010_01);
            end
         end
         // Only DATA has none of AWVALID, BREADY, done while busy.
         in_data = bus.busy && !bus.AWVALID && !bus.BREADY && !bus.done;
         chk("w_passthrough", {bus.WVALID, bus.wr_ready},
             in_data ? {bus.wr_valid, bus.WREADY} : 2'b00);
         if (w_fire) begin
            w_count++;
            if (bus.WLAST) begin
               wlast_count++;
               last_wdata_last = bus.WDATA;
            end
            if (exp_w.size() == 0) begin
               chk("w_unexpected", 1, 0);
            end else begin
               w_e = exp_w.pop_front();
               chk("w_beat", {bus.WLAST, bus.WDATA}, w_e);
               chk("w_strb", bus.WSTRB, 4'hF);
            end
         end
         if (bus.done) begin
            done_count++;
            done_cyc  = cyc;
            last_resp = bus.resp;
            if (exp_resp.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               r_e = exp_resp.pop_front();
               chk("done_resp", bus.resp, r_e);
            end
         end
      end
   end

   task automatic run_cmd(input logic [15:0] a, input logic [7:0] l,
                          input logic [31:0] base, input logic [1:0] br);
      bit legal;
      int n;
      legal = (a[1:0] == 2'b00)
           && ((int'(a[11:0]) + 4 * (int'(l) + 1)) <= 4096);
      if (legal) begin
         exp_aw.push_back({a, l});
         for (int i = 0; i <= int'(l); i++) begin
            exp_w.push_back({(i == int'(l)), base + 32'(i)});
            src_q.push_back(base + 32'(i));
         end
         exp_resp.push_back(br);
      end else begin
         exp_resp.push_back(2'b10);
      end
      bresp_cfg = br;
      @(posedge ACLK);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (!bus.cmd_ready && n < 50);
      chk("cmd_accepted", bus.cmd_ready, 1);
      @(posedge ACLK);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int start, input string name);
      int n;
      n = 0;
      while (done_count == start && n < 400) begin
         @(negedge ACLK);
         #1;
         n++;
      end
      chk({name, "_done_seen"}, done_count > start, 1);
   endtask

   int d0, w0, l0, a0, n;

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      repeat (3) @(negedge ACLK);
      @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      chk("cmd_ready_after_reset", bus.cmd_ready, 1);
      chk("busy_after_reset", bus.busy, 0);

      // basic 4-beat burst
      d0 = done_count; w0 = w_count; l0 = wlast_count;
      run_cmd(16'h0100, 8'd3, 32'hA0, 2'b00);
      wait_done(d0, "t1");
      chk("t1_awaddr", last_awaddr, 16'h0100);
      chk("t1_awlen", last_awlen, 8'd3);
      chk("t1_beats", w_count - w0, 4);
      chk("t1_last_data", last_wdata_last, 32'hA3);
      chk("t1_resp", last_resp, 2'b00);

      // single beat, AWREADY held off
      aw_delay = 3;
      a0 = aw_cycles; w0 = w_count; l0 = wlast_count; d0 = done_count;
      run_cmd(16'h0200, 8'd0, 32'h55, 2'b00);
      wait_done(d0, "t2");
      aw_delay = 0;
      chk("t2_awvalid_cycles", aw_cycles - a0, 4);
      chk("t2_beats", w_count - w0, 1);
      chk("t2_wlast", wlast_count - l0, 1);

      // 4 KB crossing rejected
      a0 = aw_cycles; d0 = done_count;
      run_cmd(16'h0FF8, 8'd3, 32'h0, 2'b00);
      wait_done(d0, "t3");
      chk("t3_no_aw", aw_cycles - a0, 0);
      chk("t3_resp", last_resp, 2'b10);
      chk("t3_latency", done_cyc - acc_cyc, 1);

      // misaligned address rejected
      a0 = aw_cycles; d0 = done_count;
      run_cmd(16'h0102, 8'd0, 32'h0, 2'b00);
      wait_done(d0, "t3b");
      chk("t3b_no_aw", aw_cycles - a0, 0);

      // burst ending exactly at the page edge is legal
      a0 = aw_cycles; d0 = done_count;
      run_cmd(16'h0FF0, 8'd3, 32'hC0, 2'b00);
      wait_done(d0, "t3c");
      chk("t3c_aw", aw_cycles - a0, 1);
      chk("t3c_resp", last_resp, 2'b00);

      // 8 beats under WREADY toggling and wr_valid gaps
      gaps = 1; wtog = 1;
      w0 = w_count; l0 = wlast_count; d0 = done_count;
      run_cmd(16'h0400, 8'd7, 32'h10, 2'b00);
      wait_done(d0, "t4");
      gaps = 0; wtog = 0;
      chk("t4_beats", w_count - w0, 8);
      chk("t4_wlast", wlast_count - l0, 1);
      chk("t4_last_data", last_wdata_last, 32'h17);

      // SLVERR passed through
      d0 = done_count;
      run_cmd(16'h0800, 8'd1, 32'h20, 2'b10);
      wait_done(d0, "t5");
      chk("t5_resp", last_resp, 2'b10);

      // stray BVALID while idle is ignored
      d0 = done_count;
      @(posedge ACLK); #1; stray = 1;
      repeat (4) begin
         @(negedge ACLK);
         chk("stray_bready", bus.BREADY, 0);
      end
      @(posedge ACLK); #1; stray = 0;
      repeat (2) @(negedge ACLK);
      chk("stray_no_done", done_count - d0, 0);

      // reset during beat 2 of a 6-beat burst
      w0 = w_count; d0 = done_count;
      run_cmd(16'h0300, 8'd5, 32'h60, 2'b00);
      n = 0;
      while (w_count - w0 < 1 && n < 100) begin
         @(negedge ACLK); #1; n++;
      end
      chk("t6_first_beat", w_count - w0, 1);
      #2;
      ARESETn = 1'b0;
      exp_aw.delete();
      exp_w.delete();
      exp_resp.delete();
      src_q.delete();
      repeat (3) @(negedge ACLK);
      chk("t6_no_done", done_count - d0, 0);
      @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      chk("t6_cmd_ready", bus.cmd_ready, 1);
      chk("t6_no_done_after", done_count - d0, 0);
      w0 = w_count; d0 = done_count;
      run_cmd(16'h0500, 8'd2, 32'h30, 2'b00);
      wait_done(d0, "t6");
      chk("t6_beats", w_count - w0, 3);
      chk("t6_last_data", last_wdata_last, 32'h32);

      repeat (3) @(negedge ACLK);
      chk("model_drained", exp_aw.size() + exp_w.size() + exp_resp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
